// File: rtl/mdio_arbiter.sv
// Round-robin arbiter sharing one MDIO driver among NUM_REQ requesters.
// Ports: req_* command in, rsp_* result out, driver trigger/done side, busy/grant_id status.
module mdio_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_write_read,
    input  logic [5*NUM_REQ-1:0]    req_reg_addr,
    input  logic [16*NUM_REQ-1:0]   req_write_data,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [15:0]             rsp_data,
    output logic                    rsp_ack,
    output logic                    rsp_timeout,
    output logic                    mdio_triger,
    output logic                    write_read,
    output logic [4:0]              reg_addr,
    output logic [15:0]             write_data,
    input  logic                    done,
    input  logic [15:0]             read_data,
    input  logic                    read_ack,
    output logic                    busy,
    output logic [1:0]              grant_id
);
    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  WAIT    = 2'd1;
    localparam logic [1:0]  RESP    = 2'd2;
    localparam logic [19:0] TO_LAST = 20'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [1:0]  last_q, last_d;
    logic [1:0]  grant_q, grant_d;
    logic [19:0] cnt_q, cnt_d;
    logic        trig_q, trig_d;
    logic        wr_q, wr_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ack_q, ack_d;
    logic        to_q, to_d;

    logic [3:0]  valid4;
    logic [1:0]  idx;
    logic [1:0]  win;
    logic        found;
    logic        accept;
    logic        sel_wr;
    logic [4:0]  sel_addr;
    logic [15:0] sel_wdata;

    // Search starts just after the last grant so every requester gets a turn.
    always_comb begin
        valid4    = 4'(req_valid);
        found     = 1'b0;
        win       = '0;
        idx       = '0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = 2'((int'(last_q) + k) % NUM_REQ);
            if (!found && valid4[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == 2'(i)) begin
                sel_wr    = req_write_read[i];
                sel_addr  = req_reg_addr[5*i +: 5];
                sel_wdata = req_write_data[16*i +: 16];
            end
        end
    end

    assign accept = (state_q == IDLE) && found;

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = accept && (win == 2'(i));
            rsp_valid[i] = (state_q == RESP) && (grant_q == 2'(i));
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        trig_d  = 1'b0;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = ack_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = sel_wr;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    grant_d = win;
                    last_d  = win;
                    trig_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // done takes priority over a timeout in the same cycle
                if (done) begin
                    rdata_d = wr_q ? read_data : 16'h0;
                    ack_d   = wr_q & read_ack;
                    to_d    = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = 16'h0;
                    ack_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 2'(NUM_REQ - 1);
            grant_q <= '0;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            to_q    <= to_d;
        end
    end

    assign mdio_triger = trig_q;
    assign write_read  = wr_q;
    assign reg_addr    = addr_q;
    assign write_data  = wdata_q;
    assign rsp_data    = rdata_q;
    assign rsp_ack     = ack_q;
    assign rsp_timeout = to_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = grant_q;
endmodule

// File: tb/tb_mdio_arbiter.sv
// Scoreboard bench for mdio_arbiter: three requesters, short timeout.
// Random commands are scored against a round-robin reference model.
module tb_mdio_arbiter;
    localparam int N     = 3;
    localparam int TMO   = 16;
    localparam int NEVER = -1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]    req_valid, req_ready, req_write_read, rsp_valid;
    logic [5*N-1:0]  req_reg_addr;
    logic [16*N-1:0] req_write_data;
    logic [15:0]     rsp_data, write_data, read_data;
    logic            rsp_ack, rsp_timeout, mdio_triger, write_read;
    logic            done, read_ack, busy;
    logic [4:0]      reg_addr;
    logic [1:0]      grant_id;

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [15:0] wd;
        int          lat;
        logic [15:0] rd;
        logic        rack;
    } cmd_t;
    typedef struct {
        int   owner;
        cmd_t c;
    } txn_t;

    cmd_t cmd_q[N][$];
    txn_t exp_cmd_q[$];
    txn_t exp_rsp_q[$];
    cmd_t drv_q[$];
    int n_pass = 0;
    int n_tot = 0;
    int m_last = N - 1;
    int cyc = 0;
    int inj_req = 0;
    int inj_ack = 0;

    mdio_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write_read(req_write_read), .req_reg_addr(req_reg_addr),
        .req_write_data(req_write_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ack(rsp_ack),
        .rsp_timeout(rsp_timeout), .mdio_triger(mdio_triger),
        .write_read(write_read), .reg_addr(reg_addr), .write_data(write_data),
        .done(done), .read_data(read_data), .read_ack(read_ack),
        .busy(busy), .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [49:0] all_outs();
        return {req_ready, rsp_valid, rsp_data, rsp_ack, rsp_timeout,
                mdio_triger, write_read, reg_addr, write_data, busy, grant_id};
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (cmd_q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(int r, logic wr, logic [4:0] a, logic [15:0] wd,
                        int lat, logic [15:0] rd, logic rack);
        cmd_t c;
        c.wr = wr; c.addr = a; c.wd = wd; c.lat = lat; c.rd = rd; c.rack = rack;
        cmd_q[r].push_back(c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pending() || exp_cmd_q.size() > 0 || exp_rsp_q.size() > 0 || busy)
               && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_within_bound", 64'(n < 3000), 1);
        repeat (2) @(negedge clk);
    endtask

    // Requesters: present queued commands, record the model's winner.
    cmd_t rc;
    int   w, got;
    always begin
        @(negedge clk);
        if (!rst_n) begin
            req_valid = '0;
            m_last = N - 1;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (cmd_q[i].size() > 0) begin
                    req_valid[i] = 1'b1;
                    req_write_read[i] = cmd_q[i][0].wr;
                    req_reg_addr[5*i +: 5] = cmd_q[i][0].addr;
                    req_write_data[16*i +: 16] = cmd_q[i][0].wd;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            #1;
            if (req_ready != '0) begin
                w = -1;
                got = -1;
                for (int k = 1; k <= N; k++)
                    if (w < 0 && cmd_q[(m_last + k) % N].size() > 0) w = (m_last + k) % N;
                for (int i = 0; i < N; i++) if (req_ready[i]) got = i;
                chk("ready_onehot", 64'($countones(req_ready)), 1);
                chk("arb_winner", 64'(got), 64'(w));
                if (w >= 0) begin
                    rc = cmd_q[w].pop_front();
                    drv_q.push_back(rc);
                    exp_cmd_q.push_back('{w, rc});
                    m_last = w;
                end
            end
        end
    end

    // MDIO driver model: answers each trigger after the scheduled latency.
    cmd_t dc;
    always begin
        @(negedge clk);
        if (mdio_triger) begin
            if (drv_q.size() > 0) begin
                dc = drv_q.pop_front();
                if (dc.lat >= 0) begin
                    repeat (dc.lat) @(negedge clk);
                    done = 1'b1;
                    read_data = dc.rd;
                    read_ack = dc.rack;
                    @(negedge clk);
                    done = 1'b0;
                    read_data = 16'($urandom);
                    read_ack = 1'($urandom);
                end
            end
        end else if (inj_req != inj_ack) begin
            done = 1'b1;
            read_data = 16'hDEAD;
            @(negedge clk);
            done = 1'b0;
            inj_ack++;
        end
    end

    // Monitor: compares driver commands and responses against the scoreboard.
    txn_t mt;
    int   trig_cyc = 0;
    bit   prev_trig = 1'b0;
    bit   chk_idle = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_rsp_q.delete();
            prev_trig = 1'b0;
            chk_idle = 1'b0;
        end else begin
            if (busy) chk("ready_low_when_busy", 64'(req_ready), 0);
            if (chk_idle) begin
                chk("busy_after_rsp", 64'(busy), 0);
                chk_idle = 1'b0;
            end
            if (mdio_triger) begin
                chk("trig_one_cycle", 64'(prev_trig), 0);
                if (exp_cmd_q.size() == 0) begin
                    chk("trig_expected", 64'(exp_cmd_q.size()), 1);
                end else begin
                    mt = exp_cmd_q.pop_front();
                    chk("grant_id", 64'(grant_id), 64'(mt.owner));
                    chk("write_read", 64'(write_read), 64'(mt.c.wr));
                    chk("reg_addr", 64'(reg_addr), 64'(mt.c.addr));
                    chk("write_data", 64'(write_data), 64'(mt.c.wd));
                    exp_rsp_q.push_back(mt);
                    trig_cyc = cyc;
                end
            end
            prev_trig = mdio_triger;
            if (rsp_valid != '0) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("rsp_expected", 64'(rsp_valid), 0);
                end else begin
                    mt = exp_rsp_q.pop_front();
                    chk("rsp_owner", 64'(rsp_valid), 64'(1) << mt.owner);
                    if (mt.c.lat == NEVER) begin
                        chk("rsp_data", 64'(rsp_data), 0);
                        chk("rsp_ack", 64'(rsp_ack), 1);
                        chk("rsp_timeout", 64'(rsp_timeout), 1);
                        chk("rsp_latency", 64'(cyc - trig_cyc), TMO);
                    end else begin
                        chk("rsp_data", 64'(rsp_data), mt.c.wr ? 64'(mt.c.rd) : 0);
                        chk("rsp_ack", 64'(rsp_ack), mt.c.wr ? 64'(mt.c.rack) : 0);
                        chk("rsp_timeout", 64'(rsp_timeout), 0);
                        chk("rsp_latency", 64'(cyc - trig_cyc), 64'(mt.c.lat + 1));
                    end
                    chk_idle = 1'b1;
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r;
        int n;
        req_valid = '0;
        req_write_read = '0;
        req_reg_addr = '0;
        req_write_data = '0;
        done = 1'b0;
        read_data = '0;
        read_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'(all_outs()), 0);
        rst_n = 1'b1;

        push(0, 1'b1, 5'h01, 16'h0000, 10, 16'h796D, 1'b0);
        wait_idle();
        push(1, 1'b0, 5'h00, 16'hB100, 4, 16'hFFFF, 1'b1);
        wait_idle();
        push(0, 1'b1, 5'h04, 16'h1111, 3, 16'hA5A5, 1'b0);
        push(1, 1'b1, 5'h05, 16'h2222, 5, 16'h5A5A, 1'b1);
        push(0, 1'b0, 5'h06, 16'h3333, 2, 16'h0F0F, 1'b0);
        wait_idle();
        push(2, 1'b1, 5'h1F, 16'h0000, NEVER, 16'h0, 1'b0);
        wait_idle();
        push(1, 1'b1, 5'h0A, 16'h0000, TMO - 1, 16'h1234, 1'b0);
        wait_idle();
        push(0, 1'b1, 5'h03, 16'h0000, 0, 16'hCAFE, 1'b1);
        wait_idle();

        inj_req++;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle_done_ignored", 64'({busy, mdio_triger, rsp_valid}), 0);
        end

        for (int t = 0; t < 60; t++) begin
            r = int'($urandom_range(0, N - 1));
            if (cmd_q[r].size() < 2)
                push(r, 1'($urandom), 5'($urandom), 16'($urandom),
                     ($urandom_range(0, 7) == 0) ? NEVER : int'($urandom_range(0, TMO - 1)),
                     16'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 12)) @(negedge clk);
        end
        wait_idle();

        push(0, 1'b1, 5'h02, 16'h0000, NEVER, 16'h0, 1'b0);
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("busy_before_reset", 64'(busy), 1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("reset_mid_wait_outputs", 64'(all_outs()), 0);
        push(2, 1'b1, 5'h12, 16'h0000, 1, 16'h2222, 1'b0);
        push(1, 1'b1, 5'h11, 16'h0000, 2, 16'h1111, 1'b0);
        push(0, 1'b1, 5'h10, 16'h0000, 3, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
